// File: rtl/stack_ctrl_gen2.sv
// Multicycle stack-machine controller: fetch/decode/pop/push/ALU/memory sequencing
// with a memory ready handshake, stack-depth tracking and HALT/fault trapping.
module stack_ctrl_gen2 #(
    parameter int OPW         = 3,
    parameter int STACK_DEPTH = 16,
    parameter int DW          = $clog2(STACK_DEPTH + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] opcode,
    input  logic           mem_ready,
    output logic           IorD,
    output logic           srcA,
    output logic           srcB,
    output logic           lda,
    output logic           ldb,
    output logic           PCsrc,
    output logic           PCwrite,
    output logic           memRead,
    output logic           IRwrite,
    output logic           tos,
    output logic           pop,
    output logic           push,
    output logic           MtoS,
    output logic           PCwriteCond,
    output logic           memWrite,
    output logic [1:0]     ALUop,
    output logic [DW-1:0]  depth,
    output logic           halted,
    output logic           fault,
    output logic [1:0]     fault_code
);

    typedef enum logic [3:0] {
        S_IF, S_DECODE, S_MEMRD, S_PUSHMEM, S_POPA, S_LOADA, S_POPB, S_LOADB,
        S_ALU, S_ALUNOT, S_PUSHRES, S_MEMWR, S_JUMP, S_BRANCH, S_HALT, S_FAULT
    } state_t;

    state_t        state_r;
    state_t        next_s;
    logic [DW-1:0] depth_r;
    logic [1:0]    code_r;
    logic [1:0]    code_next_s;
    logic [2:0]    base_s;
    logic          ext_nz_s;
    logic          halt_op_s;
    logic          illegal_s;
    logic          short_s;
    logic          over_s;

    // Extension field only exists when the opcode is wider than the base 3 bits.
    generate
        if (OPW > 3) begin : g_ext
            assign ext_nz_s = |opcode[OPW-1:3];
        end else begin : g_noext
            assign ext_nz_s = 1'b0;
        end
    endgenerate

    assign base_s    = opcode[2:0];
    assign halt_op_s = (OPW > 3) && (&opcode);
    assign illegal_s = ext_nz_s && !halt_op_s;
    assign short_s   = (((base_s == 3'd0) || (base_s == 3'd1) || (base_s == 3'd2)) && (depth_r < DW'(2))) ||
                       (((base_s == 3'd3) || (base_s == 3'd5) || (base_s == 3'd7)) && (depth_r == DW'(0)));
    assign over_s    = (base_s == 3'd4) && (depth_r == DW'(STACK_DEPTH));

    // State, depth and fault-code registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= S_IF;
            depth_r <= '0;
            code_r  <= 2'b00;
        end else begin
            state_r <= next_s;
            code_r  <= code_next_s;
            if (push) begin
                depth_r <= depth_r + DW'(1);
            end else if (pop) begin
                depth_r <= depth_r - DW'(1);
            end else begin
                depth_r <= depth_r;
            end
        end
    end

    // Next-state logic; DECODE checks are prioritised top to bottom.
    always_comb begin
        next_s      = state_r;
        code_next_s = code_r;
        case (state_r)
            S_IF:      next_s = mem_ready ? S_DECODE : S_IF;
            S_DECODE: begin
                if (illegal_s) begin
                    next_s      = S_FAULT;
                    code_next_s = 2'b11;
                end else if (halt_op_s) begin
                    next_s = S_HALT;
                end else if (short_s) begin
                    next_s      = S_FAULT;
                    code_next_s = 2'b01;
                end else if (over_s) begin
                    next_s      = S_FAULT;
                    code_next_s = 2'b10;
                end else begin
                    case (base_s)
                        3'd4:    next_s = S_MEMRD;
                        3'd6:    next_s = S_JUMP;
                        3'd7:    next_s = S_BRANCH;
                        default: next_s = S_POPA;
                    endcase
                end
            end
            S_MEMRD:   next_s = mem_ready ? S_PUSHMEM : S_MEMRD;
            S_PUSHMEM: next_s = S_IF;
            S_POPA:    next_s = S_LOADA;
            S_LOADA: begin
                case (base_s)
                    3'd5:    next_s = S_MEMWR;
                    3'd3:    next_s = S_ALUNOT;
                    default: next_s = S_POPB;
                endcase
            end
            S_POPB:    next_s = S_LOADB;
            S_LOADB:   next_s = S_ALU;
            S_ALU:     next_s = S_PUSHRES;
            S_ALUNOT:  next_s = S_PUSHRES;
            S_PUSHRES: next_s = S_IF;
            S_MEMWR:   next_s = mem_ready ? S_IF : S_MEMWR;
            S_JUMP:    next_s = S_IF;
            S_BRANCH:  next_s = S_IF;
            S_HALT:    next_s = S_HALT;
            S_FAULT:   next_s = S_FAULT;
            default:   next_s = S_IF;
        endcase
    end

    // Moore strobe decode; everything is held at zero while reset is low.
    always_comb begin
        IorD = 1'b0; srcA = 1'b0; srcB = 1'b0; lda = 1'b0; ldb = 1'b0;
        PCsrc = 1'b0; PCwrite = 1'b0; memRead = 1'b0; IRwrite = 1'b0; tos = 1'b0;
        pop = 1'b0; push = 1'b0; MtoS = 1'b0; PCwriteCond = 1'b0; memWrite = 1'b0;
        ALUop = 2'b00; halted = 1'b0; fault = 1'b0;
        if (rst) begin
            depth      = depth_r;
            fault_code = code_r;
            case (state_r)
                S_IF: begin
                    srcA    = 1'b1;
                    srcB    = 1'b1;
                    memRead = 1'b1;
                    PCwrite = mem_ready;
                    IRwrite = mem_ready;
                end
                S_DECODE:  tos = 1'b1;
                S_MEMRD:   begin IorD = 1'b1; memRead = 1'b1; end
                S_PUSHMEM: begin MtoS = 1'b1; push = 1'b1; end
                S_POPA:    pop = 1'b1;
                S_LOADA:   lda = 1'b1;
                S_POPB:    pop = 1'b1;
                S_LOADB:   ldb = 1'b1;
                S_ALU:     ALUop = opcode[1:0];
                S_ALUNOT:  ALUop = 2'b11;
                S_PUSHRES: push = 1'b1;
                S_MEMWR:   begin IorD = 1'b1; memWrite = 1'b1; end
                S_JUMP:    begin PCsrc = 1'b1; PCwrite = 1'b1; end
                S_BRANCH:  begin PCsrc = 1'b1; PCwriteCond = 1'b1; end
                S_HALT:    halted = 1'b1;
                S_FAULT:   fault = 1'b1;
                default:   ;
            endcase
        end else begin
            depth      = '0;
            fault_code = 2'b00;
        end
    end

endmodule

// File: tb/tb_stack_ctrl_gen2.sv
// Bench for stack_ctrl_gen2 (OPW=5, STACK_DEPTH=2): directed literal checks plus
// randomized instruction streams compared each cycle against a step-queue model.
module tb_stack_ctrl_gen2;
    localparam int OPW = 5;
    localparam int SD  = 2;
    localparam int DW  = 2;
    localparam int ALL_ONES = (1 << OPW) - 1;

    localparam int T_FETCH = 0, T_DEC = 1, T_RD = 2, T_PUSHM = 3, T_POP = 4, T_LDA = 5, T_LDB = 6,
                   T_OP = 7, T_PUSHR = 8, T_WR = 9, T_J = 10, T_BR = 11, T_HALT = 12, T_FAULT = 13;

    typedef struct packed {
        logic iord, srca, srcb, lda, ldb, pcsrc, pcwrite, memread, irwrite, tos, pop, push, mtos, pcwc, memwrite;
        logic [1:0] aluop;
    } strobes_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic mem_ready = 1'b0;
    logic [OPW-1:0] opcode = '0;
    logic IorD, srcA, srcB, lda, ldb, PCsrc, PCwrite, memRead, IRwrite, tos, pop, push, MtoS, PCwriteCond, memWrite;
    logic [1:0] ALUop;
    logic [DW-1:0] depth;
    logic halted, fault;
    logic [1:0] fault_code;
    strobes_t dut_s;

    stack_ctrl_gen2 #(.OPW(OPW), .STACK_DEPTH(SD), .DW(DW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .IorD(IorD), .srcA(srcA), .srcB(srcB), .lda(lda), .ldb(ldb), .PCsrc(PCsrc),
        .PCwrite(PCwrite), .memRead(memRead), .IRwrite(IRwrite), .tos(tos), .pop(pop),
        .push(push), .MtoS(MtoS), .PCwriteCond(PCwriteCond), .memWrite(memWrite),
        .ALUop(ALUop), .depth(depth), .halted(halted), .fault(fault), .fault_code(fault_code)
    );

    assign dut_s = {IorD, srcA, srcB, lda, ldb, PCsrc, PCwrite, memRead, IRwrite, tos, pop, push,
                    MtoS, PCwriteCond, memWrite, ALUop};

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model: instruction = queue of micro-steps
    int m_step = T_FETCH;
    int m_q[$];
    int m_depth = 0;
    int m_code = 0;
    int m_alu = 0;

    function automatic void m_advance();
        if (m_q.size() == 0) m_step = T_FETCH;
        else m_step = m_q.pop_front();
    endfunction

    function automatic void m_decode(input int op);
        int lo, ext, need;
        lo  = op % 8;
        ext = op / 8;
        need = (lo <= 2) ? 2 : ((lo == 3 || lo == 5 || lo == 7) ? 1 : 0);
        if (ext != 0 && op != ALL_ONES) begin
            m_step = T_FAULT; m_code = 3;
        end else if (op == ALL_ONES) begin
            m_step = T_HALT;
        end else if (m_depth < need) begin
            m_step = T_FAULT; m_code = 1;
        end else if (lo == 4 && m_depth == SD) begin
            m_step = T_FAULT; m_code = 2;
        end else begin
            case (lo)
                4: m_q = '{T_RD, T_PUSHM};
                5: m_q = '{T_POP, T_LDA, T_WR};
                6: m_q = '{T_J};
                7: m_q = '{T_BR};
                3: begin m_alu = 3; m_q = '{T_POP, T_LDA, T_OP, T_PUSHR}; end
                default: begin m_alu = lo; m_q = '{T_POP, T_LDA, T_POP, T_LDB, T_OP, T_PUSHR}; end
            endcase
            m_advance();
        end
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            m_step = T_FETCH; m_q.delete(); m_depth = 0; m_code = 0;
        end else begin
            case (m_step)
                T_FETCH: if (mem_ready) m_step = T_DEC;
                T_DEC:   m_decode(int'(opcode));
                T_RD, T_WR: if (mem_ready) m_advance();
                T_HALT, T_FAULT: ;
                default: begin
                    if (m_step == T_POP) m_depth--;
                    if (m_step == T_PUSHM || m_step == T_PUSHR) m_depth++;
                    m_advance();
                end
            endcase
        end
    end

    function automatic strobes_t model_strobes();
        strobes_t s;
        s = '0;
        case (m_step)
            T_FETCH: begin s.srca = 1'b1; s.srcb = 1'b1; s.memread = 1'b1; s.pcwrite = mem_ready; s.irwrite = mem_ready; end
            T_DEC:   s.tos = 1'b1;
            T_RD:    begin s.iord = 1'b1; s.memread = 1'b1; end
            T_PUSHM: begin s.mtos = 1'b1; s.push = 1'b1; end
            T_POP:   s.pop = 1'b1;
            T_LDA:   s.lda = 1'b1;
            T_LDB:   s.ldb = 1'b1;
            T_OP:    s.aluop = 2'(m_alu);
            T_PUSHR: s.push = 1'b1;
            T_WR:    begin s.iord = 1'b1; s.memwrite = 1'b1; end
            T_J:     begin s.pcsrc = 1'b1; s.pcwrite = 1'b1; end
            T_BR:    begin s.pcsrc = 1'b1; s.pcwc = 1'b1; end
            default: ;
        endcase
        if (!rst) s = '0;
        return s;
    endfunction

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [22:0] exp_v, got_v;
        exp_v = {model_strobes(),
                 rst ? DW'(m_depth) : DW'(0),
                 rst && (m_step == T_HALT),
                 rst && (m_step == T_FAULT),
                 rst ? 2'(m_code) : 2'b00};
        got_v = {dut_s, depth, halted, fault, fault_code};
        chk("cycle_model", 32'(got_v), 32'(exp_v));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [OPW-1:0] pick_op();
        int r;
        r = $urandom_range(0, 19);
        if (r == 0) return OPW'(ALL_ONES);
        if (r == 1) return OPW'($urandom_range(8, 30));
        if (r < 7) return OPW'(4);
        return OPW'($urandom_range(0, 7));
    endfunction

    initial begin
        int rd, pw, iw, pw3;
        strobes_t acc;

        // Reset and the push/push/add sequence
        rst = 1'b0; mem_ready = 1'b1; opcode = '0;
        cyc(); cyc(); #1;
        chk("rst_forced_zero", {dut_s, depth, halted, fault, fault_code}, 0);
        rst = 1'b1; opcode = 5'd4; #1;
        chk("if_after_rst", memRead, 1);
        chk("depth_start", depth, 0);
        repeat (4) cyc(); #1;
        chk("push1_depth", depth, 1);
        chk("push1_back_in_if", memRead, 1);
        repeat (4) cyc(); #1;
        chk("push2_depth", depth, 2);
        opcode = 5'd0;
        repeat (6) cyc(); #1;
        chk("add_alu_state", dut_s, 0);
        cyc(); #1;
        chk("add_pushres", push, 1);
        cyc(); #1;
        chk("add_8cyc_if", {memRead, IorD}, 2'b10);
        chk("add_depth", depth, 1);

        // Fetch stalled for three cycles
        rd = 0; pw = 0; iw = 0; pw3 = 0;
        opcode = 5'd6;
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            #1;
            rd += memRead; pw += PCwrite; iw += IRwrite;
            if (i == 3) pw3 = PCwrite;
            cyc();
        end
        chk("stall_memread_cycles", rd, 4);
        chk("stall_pcwrite_pulses", pw, 1);
        chk("stall_irwrite_pulses", iw, 1);
        chk("stall_pcwrite_4th", pw3, 1);
        cyc(); cyc(); #1;
        chk("jmp_back_in_if", memRead, 1);

        // Underflow on sub with an empty stack
        rst = 1'b0; cyc(); rst = 1'b1; opcode = 5'd1;
        cyc(); cyc(); #1;
        chk("underflow_fault", fault, 1);
        chk("underflow_code", fault_code, 2'b01);
        acc = '0;
        repeat (10) begin cyc(); #1; acc = acc | dut_s; end
        chk("fault_strobes_quiet", acc, 0);
        chk("fault_sticky", fault, 1);

        // Overflow on a third push
        rst = 1'b0; cyc(); rst = 1'b1; opcode = 5'd4;
        repeat (8) cyc(); #1;
        chk("full_depth", depth, 2);
        cyc(); cyc(); #1;
        chk("overflow_code", fault_code, 2'b10);
        chk("overflow_depth", depth, 2);

        // HALT and illegal opcode in the extension space
        rst = 1'b0; cyc(); rst = 1'b1; opcode = 5'b11111;
        cyc(); cyc(); #1;
        chk("halt_halted", halted, 1);
        chk("halt_no_fault", fault, 0);
        rst = 1'b0; cyc(); rst = 1'b1; opcode = 5'b01000;
        cyc(); cyc(); #1;
        chk("illegal_code", fault_code, 2'b11);
        chk("illegal_not_halted", halted, 0);

        // Reset during a stalled store
        rst = 1'b0; cyc(); rst = 1'b1; mem_ready = 1'b1; opcode = 5'd4;
        repeat (4) cyc();
        opcode = 5'd5;
        cyc(); mem_ready = 1'b0;
        cyc(); cyc(); cyc(); #1;
        chk("memwr_active", memWrite, 1);
        cyc(); #1;
        chk("memwr_hold", memWrite, 1);
        rst = 1'b0; #1;
        chk("memwr_drop_on_rst", memWrite, 0);
        cyc(); rst = 1'b1; mem_ready = 1'b1; opcode = 5'd4; #1;
        chk("post_rst_if", {memRead, IorD, depth}, 4'b1000);
        repeat (3) cyc(); #1;
        chk("post_rst_push_before", depth, 0);
        cyc(); #1;
        chk("post_rst_push_after", depth, 1);

        // Randomized instruction stream
        for (int c = 0; c < 4000; c++) begin
            cyc();
            mem_ready = ($urandom_range(0, 3) != 0);
            if (!rst) rst = 1'b1;
            else if (m_step == T_HALT || m_step == T_FAULT) rst = ($urandom_range(0, 2) != 0);
            else if ($urandom_range(0, 199) == 0) rst = 1'b0;
            if (m_step == T_FETCH) opcode = pick_op();
        end
        cyc(); cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/stack_ctrl_gen2.md
# stack_ctrl_gen2

Parametrised multicycle controller for the stack-machine datapath, successor to the fixed 3-bit-opcode controller. It sequences fetch, decode, stack pop/push, ALU and memory phases, and drives the same datapath strobes. It adds three things the earlier controller lacked: a memory ready handshake, stack-depth tracking with overflow/underflow detection, and a wider opcode space with HALT and illegal-opcode trapping. It sits between the instruction register and the datapath/stack, in place of the previous controller.

## Interface
- OPW, 3 — opcode width; must be ≥3.
- STACK_DEPTH, 16 — number of stack entries; must be ≥2.
- DW, $clog2(STACK_DEPTH+1) — width of the depth counter.
- clk  in  1  — single clock; all state updates on its rising edge.
- rst  in  1  — reset, synchronous and active-low.
- opcode  in  OPW  — current IR opcode field.
- mem_ready  in  1  — memory completes the read/write in the current cycle.
- IorD, srcA, srcB, lda, ldb, PCsrc, PCwrite, memRead, IRwrite, tos, pop, push, MtoS, PCwriteCond, memWrite  out  1 each — datapath strobes, with the same meaning as in the existing datapath.
- ALUop  out  2  — ALU function: 0 add, 1 sub, 2 and, 3 not.
- depth  out  DW  — current stack occupancy.
- halted  out  1  — sticky; the controller is in HALT.
- fault  out  1  — sticky; the controller is in FAULT.
- fault_code  out  2  — 01 underflow, 10 overflow, 11 illegal opcode, 00 none.

## Operation
- Base opcodes use the low 3 bits: 000 add, 001 sub, 010 and, 011 not, 100 push-from-mem, 101 store(pop-to-mem), 110 jmp, 111 jz.
- Extension bits: if OPW>3 and opcode[OPW-1:3] is nonzero:
  - opcode all-ones → HALT.
  - any other nonzero value → illegal-opcode fault.
  - When OPW=3, HALT does not exist.
- State machine states: IF, DECODE, MEMRD, PUSHMEM, POPA, LOADA, POPB, LOADB, ALU, ALUNOT, PUSHRES, MEMWR, JUMP, BRANCH, HALT, FAULT.
- IF: srcA=srcB=1, ALUop=0, PCsrc=0, IorD=0, memRead=1.
  - PCwrite=IRwrite=1 only in the cycle mem_ready=1.
  - Stays in IF while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: tos=1. Checks run in this order, first match wins:
  1. Illegal opcode → FAULT, code 11.
  2. HALT opcode → HALT.
  3. Operand shortfall → FAULT, code 01:
     - binary ops (000/001/010) need depth≥2;
     - not/store/jz need depth≥1.
  4. Push (100) with depth==STACK_DEPTH → FAULT, code 10.
  5. Otherwise dispatch: 100→MEMRD, 110→JUMP, 111→BRANCH, others→POPA.
- MEMRD: IorD=1, memRead=1. Holds until mem_ready=1, then → PUSHMEM.
- PUSHMEM: MtoS=1, push=1, then → IF.
- POPA: pop=1, then → LOADA.
- LOADA: lda=1, then 101→MEMWR, 011→ALUNOT, else→POPB.
- MEMWR: IorD=1, memWrite=1. Holds until mem_ready=1, then → IF.
- POPB: pop=1 → LOADB: ldb=1 → ALU: ALUop=opcode[1:0] → PUSHRES.
- ALUNOT: ALUop=3 → PUSHRES.
- PUSHRES: push=1, then → IF.
- JUMP: PCsrc=1, PCwrite=1, then → IF.
- BRANCH: PCsrc=1, PCwriteCond=1, then → IF.
- HALT and FAULT are absorbing: all strobes are 0, and only reset exits them.
- Strobes not listed for a state are 0.
- depth counter:
  - +1 at each edge where push=1; −1 at each edge where pop=1.
  - push and pop are never both 1 in the same cycle.
  - The DECODE checks guarantee depth never wraps.

## Timing
- While rst=0 at a rising edge: next state is IF, depth=0, halted=0, fault=0, fault_code=00.
- While rst is low, every output is forced to 0 combinationally, including depth, halted and fault.
- Reset applied mid-instruction (in any state, including a memory wait) aborts the instruction on that edge. No strobe from the aborted state is asserted after the edge.
- Outputs are Moore (decoded from state). The only Mealy terms are PCwrite and IRwrite in IF, which are gated by mem_ready.
- Instruction latency with mem_ready tied to 1:

  | Instruction | Cycles |
  |---|---|
  | push | 4 |
  | store | 5 |
  | jmp / jz | 3 |
  | not | 6 |
  | add / sub / and | 8 |

  Each cycle that mem_ready=0 during IF, MEMRD or MEMWR adds one cycle.
- halted and fault assert on the first cycle in the HALT or FAULT state. fault_code is valid whenever fault=1.
- depth reflects a push or pop on the cycle after the strobe.

## Test plan
- Reset, then push(100), push, add(000), with mem_ready=1:
  - depth sequence 0→1→2→1;
  - ALU state shows ALUop=0;
  - add takes exactly 8 cycles from IF to the next IF.
- Fetch with mem_ready held low for 3 cycles:
  - memRead stays 1 for 4 cycles;
  - PCwrite and IRwrite pulse exactly once, in the 4th cycle.
- From reset, issue sub(001) with depth=0:
  - fault=1 and fault_code=01 on the cycle after DECODE;
  - all strobes stay 0 for 10 further cycles.
- With STACK_DEPTH=2, do 2 pushes then a 3rd push:
  - fault_code=10;
  - depth stays 2.
- With OPW=5:
  - opcode 11111 → halted=1;
  - after reset, opcode 01000 → fault_code=11.
- Assert rst=0 during MEMWR wait:
  - memWrite drops immediately;
  - next state is IF with depth=0;
  - a subsequent push starts with depth 0→1.
